// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU cell-colour RAM and its clients.
// Geometry: 40x30 cells, 4-bit colour per cell, four cells per 16-bit word,
// 10 words per row, 300 words total.
// Contents: cmd_op_t command encoding, geometry constants, nib_merge() to
// replace one nibble of a RAM word, and word_full() to test whether a whole
// word lies inside an inclusive column span.
package gpu_pkg;

  typedef enum logic [1:0] {
    OP_SET_CELL  = 2'd0,
    OP_FILL_RECT = 2'd1,
    OP_CLEAR     = 2'd2,
    OP_RSVD      = 2'd3
  } cmd_op_t;

  localparam int GPU_COLS          = 40;
  localparam int GPU_ROWS          = 30;
  localparam int GPU_WORDS_PER_ROW = 10;
  localparam int GPU_WORDS         = 300;

  // Cell x[1:0]=0 lives in bits [15:12], x[1:0]=3 in bits [3:0].
  function automatic logic [15:0] nib_merge(input logic [15:0] word,
                                            input logic [1:0]  idx,
                                            input logic [3:0]  color);
    logic [15:0] w;
    w = word;
    case (idx)
      2'd0:    w[15:12] = color;
      2'd1:    w[11:8]  = color;
      2'd2:    w[7:4]   = color;
      default: w[3:0]   = color;
    endcase
    return w;
  endfunction

  // True when the word holding cell x starts at x and its last cell is <= x1,
  // i.e. all four nibbles get overwritten and the old contents do not matter.
  function automatic logic word_full(input logic [5:0] x, input logic [5:0] x1);
    return (x[1:0] == 2'd0) && ({x[5:2], 2'b11} <= x1);
  endfunction

endpackage

// File: rtl/gpu_cell_writer_if.sv
// Bus bundle between a CPU-side master (command source plus the RAM it owns)
// and gpu_cell_writer.
//   cmd_*     : draw command handshake (valid/ready) and operands
//   mem_*     : RAM write port, addr/data/wren out of the writer, q back in
//   busy/done/err : writer status
// Modports: master = CPU/RAM side, slave = writer.
interface gpu_cell_writer_if;
  import gpu_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  cmd_op_t     cmd_op;
  logic [5:0]  cmd_x0;
  logic [4:0]  cmd_y0;
  logic [5:0]  cmd_x1;
  logic [4:0]  cmd_y1;
  logic [3:0]  cmd_color;

  logic [8:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic [15:0] mem_q;

  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, mem_q,
    input  cmd_ready, mem_addr, mem_data, mem_wren, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, mem_q,
    output cmd_ready, mem_addr, mem_data, mem_wren, busy, done, err
  );

endinterface

// File: rtl/gpu_cell_addr.sv
// Combinational cell -> RAM location map.
//   x    in  6  cell column
//   y    in  5  cell row
//   addr out 9  word address (x>>2) + y*10
//   nib  out 2  nibble index inside the word (x[1:0])
// y*10 is formed as (y<<3)+(y<<1) at 9 bits; max result is 299.
module gpu_cell_addr (
  input  logic [5:0] x,
  input  logic [4:0] y,
  output logic [8:0] addr,
  output logic [1:0] nib
);

  logic [8:0] y9;

  assign y9   = {4'd0, y};
  assign addr = {5'd0, x[5:2]} + (y9 << 3) + (y9 << 1);
  assign nib  = x[1:0];

endmodule

// File: rtl/gpu_cell_writer.sv
// CPU-side writer for the GPU cell-colour RAM. Turns SET_CELL / FILL_RECT /
// CLEAR commands into read-modify-write traffic on the RAM port.
//   clk    in  system clock (RAM port is clocked on ~clk)
//   rst_n  in  asynchronous active-low reset; aborts any command in flight
//   bus    slave modport of gpu_cell_writer_if (command, RAM port, status)
// Parameters: RD_LAT (cycles from addr to q, >=1), COLS, ROWS.
// Build option GPU_CELL_WRITER_WORD_MERGE_EN: FILL_RECT words fully inside
// [X0,X1] are written directly as {4{COLOR}} without the read.
module gpu_cell_writer
  import gpu_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int COLS   = GPU_COLS,
  parameter int ROWS   = GPU_ROWS
) (
  input  logic                clk,
  input  logic                rst_n,
  gpu_cell_writer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_WRITE, S_NEXT, S_CLR
  } state_t;

  localparam logic [5:0] COLS6     = 6'(COLS);
  localparam logic [4:0] ROWS5     = 5'(ROWS);
  localparam logic [3:0] WAIT_LAST = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

  state_t      state, state_n;

  // Latched command window; cursor walks it word by word, x first then y.
  logic [5:0]  x0_q, x1_q, cur_x;
  logic [4:0]  y1_q, cur_y;
  logic [3:0]  color_q;
  logic [15:0] cap_q;
  logic [3:0]  wcnt;
  logic        done_q, err_q;

  logic        accept, bad;
  logic [5:0]  cx1;
  logic [4:0]  cy1;
  logic [8:0]  cell_addr;
  logic [1:0]  cell_nib;
  logic [3:0]  mask;
  logic [15:0] merged;
  logic        row_last, cell_last, rd_last;
  logic [5:0]  nx;
  logic [4:0]  ny;
  logic        first_skip, next_skip;

  gpu_cell_addr u_addr (
    .x    (cur_x),
    .y    (cur_y),
    .addr (cell_addr),
    .nib  (cell_nib)
  );

  assign accept = bus.cmd_valid && (state == S_IDLE);

  // SET_CELL is walked as a 1x1 rectangle so one datapath covers both ops.
  assign cx1 = (bus.cmd_op == OP_FILL_RECT) ? bus.cmd_x1 : bus.cmd_x0;
  assign cy1 = (bus.cmd_op == OP_FILL_RECT) ? bus.cmd_y1 : bus.cmd_y0;

  // CLEAR ignores its coordinate operands, so they are not range checked.
  always_comb begin
    bad = 1'b0;
    case (bus.cmd_op)
      OP_SET_CELL:  bad = (bus.cmd_x0 >= COLS6) || (bus.cmd_y0 >= ROWS5);
      OP_FILL_RECT: bad = (bus.cmd_x0 >= COLS6) || (bus.cmd_y0 >= ROWS5) ||
                          (bus.cmd_x1 >= COLS6) || (bus.cmd_y1 >= ROWS5) ||
                          (bus.cmd_x1 < bus.cmd_x0) || (bus.cmd_y1 < bus.cmd_y0);
      OP_CLEAR:     bad = 1'b0;
      default:      bad = 1'b1;
    endcase
  end

  // cur_x equals X0 on the first word of a row (nibbles below X0 kept) and is
  // word aligned afterwards; nibbles past X1 are kept on the last word.
  always_comb begin
    merged = cap_q;
    mask   = '0;
    for (int i = 0; i < 4; i++) begin
      mask[i] = (2'(i) >= cell_nib) && ({cur_x[5:2], 2'(i)} <= x1_q);
      if (mask[i]) merged = nib_merge(merged, 2'(i), color_q);
    end
  end

  assign row_last  = (cur_x[5:2] == x1_q[5:2]);
  assign cell_last = row_last && (cur_y == y1_q);
  assign nx        = row_last ? x0_q : {cur_x[5:2] + 4'd1, 2'b00};
  assign ny        = row_last ? cur_y + 5'd1 : cur_y;

  // q is sampled on the edge closing the last read/wait cycle.
  assign rd_last = ((state == S_READ) && (RD_LAT == 1)) ||
                   ((state == S_WAIT) && (wcnt == WAIT_LAST));

`ifdef GPU_CELL_WRITER_WORD_MERGE_EN
  assign first_skip = (bus.cmd_op == OP_FILL_RECT) && word_full(bus.cmd_x0, cx1);
  assign next_skip  = word_full(nx, x1_q);
`else
  assign first_skip = 1'b0;
  assign next_skip  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
      color_q <= '0;
      cap_q   <= '0;
      wcnt    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= ((state == S_NEXT) || (state == S_CLR)) && cell_last;
      err_q  <= accept && bad;
      if (accept && !bad) begin
        color_q <= bus.cmd_color;
        if (bus.cmd_op == OP_CLEAR) begin
          // Full-screen window: walking it word by word yields addrs 0..299.
          x0_q  <= '0;
          x1_q  <= COLS6 - 6'd1;
          y1_q  <= ROWS5 - 5'd1;
          cur_x <= '0;
          cur_y <= '0;
        end else begin
          x0_q  <= bus.cmd_x0;
          x1_q  <= cx1;
          y1_q  <= cy1;
          cur_x <= bus.cmd_x0;
          cur_y <= bus.cmd_y0;
        end
      end
      if ((state == S_NEXT) || (state == S_CLR)) begin
        cur_x <= nx;
        cur_y <= ny;
      end
      if (state == S_READ)      wcnt <= '0;
      else if (state == S_WAIT) wcnt <= wcnt + 4'd1;
      if (rd_last) cap_q <= bus.mem_q;
    end
  end

  always_comb begin
    state_n       = state;
    bus.cmd_ready = (state == S_IDLE);
    bus.busy      = (state != S_IDLE);
    bus.mem_wren  = (state == S_WRITE) || (state == S_CLR);
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    bus.done      = done_q;
    bus.err       = err_q;

    if (state inside {S_READ, S_WAIT, S_WRITE, S_CLR}) bus.mem_addr = cell_addr;
    // In CLR the mask is always full, so merged is {4{color}} regardless of cap_q.
    if (bus.mem_wren) bus.mem_data = merged;

    case (state)
      S_IDLE:
        if (accept && !bad) begin
          if (bus.cmd_op == OP_CLEAR) state_n = S_CLR;
          else                        state_n = first_skip ? S_WRITE : S_READ;
        end
      S_READ:  state_n = rd_last ? S_WRITE : S_WAIT;
      S_WAIT:  if (rd_last) state_n = S_WRITE;
      S_WRITE: state_n = S_NEXT;
      S_NEXT:  state_n = cell_last ? S_IDLE : (next_skip ? S_WRITE : S_READ);
      S_CLR:   if (cell_last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gpu_cell_writer.sv
// Self-checking bench for gpu_cell_writer with a negedge RAM model and a
// cell-level reference picture of the screen.
module tb_gpu_cell_writer;
  import gpu_pkg::*;

`ifdef GPU_CELL_WRITER_WORD_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif
  localparam int LIMIT = 2000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpu_cell_writer_if bif();

  gpu_cell_writer #(.RD_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // RAM model: port clocked on the falling edge, one-cycle read latency.
  logic [15:0] ram [0:299] = '{default: 16'h0};
  logic [15:0] mdl [0:299] = '{default: 16'h0};
  logic [15:0] q = 16'h0;
  logic        pre_we = 1'b0;
  logic [8:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  assign bif.mem_q = q;

  always @(negedge clk) begin
    if (pre_we)            ram[pre_addr] <= pre_data;
    else if (bif.mem_wren) ram[bif.mem_addr] <= bif.mem_data;
    q <= ram[bif.mem_addr];
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic [24:0] wq [$];   // {addr, data} of every write of the last command

  int  cyc, nwr, nrmw;
  bit  got_done, got_err, busy1, hit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ram_diffs();
    int n = 0;
    for (int i = 0; i < 300; i++) if (ram[i] !== mdl[i]) n++;
    return n;
  endfunction

  // Issues one command and follows it until DONE/ERR (bounded). A write is
  // counted as read-modify-write when the previous cycle was a busy read of
  // the same address.
  task automatic run_cmd(input cmd_op_t op, input int x0, input int y0,
                         input int x1, input int y1, input logic [3:0] col);
    bit pb, pw;
    logic [8:0] pa;
    @(negedge clk);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = op;
    bif.cmd_x0    = 6'(x0);
    bif.cmd_y0    = 5'(y0);
    bif.cmd_x1    = 6'(x1);
    bif.cmd_y1    = 5'(y1);
    bif.cmd_color = col;
    @(posedge clk);
    #1 bif.cmd_valid = 1'b0;
    cyc = 0; nwr = 0; nrmw = 0; got_done = 0; got_err = 0; busy1 = 0;
    pb = 0; pw = 0; pa = '0;
    wq.delete();
    while (!(got_done || got_err) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy1 = bif.busy;
      if (bif.mem_wren) begin
        nwr++;
        wq.push_back({bif.mem_addr, bif.mem_data});
        if (pb && !pw && pa == bif.mem_addr) nrmw++;
      end
      pb = bif.busy; pw = bif.mem_wren; pa = bif.mem_addr;
      got_done = bif.done;
      got_err  = bif.err;
    end
    chk("cmd_completes", 32'(got_done | got_err), 32'd1);
    chk("done_err_excl", 32'(got_done & got_err), 32'd0);
  endtask

  // Valid SET_CELL / FILL_RECT: expectations derived from the rectangle.
  task automatic fill_check(input cmd_op_t op, input int x0, input int y0,
                            input int x1, input int y1, input logic [3:0] col);
    int ex1, ey1, rows, ecyc, ewr, ermw;
    bit full;
    ex1  = (op == OP_SET_CELL) ? x0 : x1;
    ey1  = (op == OP_SET_CELL) ? y0 : y1;
    rows = ey1 - y0 + 1;
    ecyc = 1; ewr = 0; ermw = 0;
    for (int w = x0 / 4; w <= ex1 / 4; w++) begin
      full = MERGE && (op == OP_FILL_RECT) && (4 * w >= x0) && (4 * w + 3 <= ex1);
      ewr  += rows;
      ecyc += rows * (full ? 2 : 3);
      if (!full) ermw += rows;
    end
    for (int y = y0; y <= ey1; y++)
      for (int x = x0; x <= ex1; x++)
        mdl[x / 4 + y * 10][(15 - 4 * (x % 4)) -: 4] = col;
    run_cmd(op, x0, y0, x1, y1, col);
    chk("draw_done",   32'(got_done), 32'd1);
    chk("draw_busy",   32'(busy1), 32'd1);
    chk("draw_cycles", 32'(cyc), 32'(ecyc));
    chk("draw_writes", 32'(nwr), 32'(ewr));
    chk("draw_rmw",    32'(nrmw), 32'(ermw));
    chk("draw_ram",    32'(ram_diffs()), 32'd0);
  endtask

  task automatic err_check(input cmd_op_t op, input int x0, input int y0,
                           input int x1, input int y1);
    run_cmd(op, x0, y0, x1, y1, 4'h9);
    chk("err_pulse",  32'(got_err), 32'd1);
    chk("err_cycle",  32'(cyc), 32'd1);
    chk("err_nowr",   32'(nwr), 32'd0);
    chk("err_nobusy", 32'(busy1), 32'd0);
    chk("err_ram",    32'(ram_diffs()), 32'd0);
  endtask

  logic [24:0] exp3 [6];
  int bad_seq, rx0, rx1, ry0, ry1;
  cmd_op_t rop;

  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_op    = OP_SET_CELL;
    bif.cmd_x0 = '0; bif.cmd_y0 = '0; bif.cmd_x1 = '0; bif.cmd_y1 = '0;
    bif.cmd_color = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bif.cmd_ready), 32'd1);
    chk("rst_busy",  32'(bif.busy), 32'd0);
    chk("rst_wren",  32'(bif.mem_wren), 32'd0);
    chk("rst_addr",  32'(bif.mem_addr), 32'd0);
    chk("rst_data",  32'(bif.mem_data), 32'd0);
    chk("rst_done",  32'({bif.done, bif.err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // SET_CELL x=5 y=2 colour F
    fill_check(OP_SET_CELL, 5, 2, 0, 0, 4'hF);
    chk("set_write", 32'(wq[0]), 32'({9'd21, 16'h0F00}));

    // FILL_RECT (2,0)-(9,1) colour 7
    exp3[0] = {9'd0,  16'h0077}; exp3[1] = {9'd1,  16'h7777}; exp3[2] = {9'd2,  16'h7700};
    exp3[3] = {9'd10, 16'h0077}; exp3[4] = {9'd11, 16'h7777}; exp3[5] = {9'd12, 16'h7700};
    fill_check(OP_FILL_RECT, 2, 0, 9, 1, 4'h7);
    bad_seq = 0;
    for (int i = 0; i < 6; i++) if (i >= wq.size() || wq[i] !== exp3[i]) bad_seq++;
    chk("fill_seq", 32'(bad_seq), 32'd0);

    // Preserved neighbours: preload 0x1234 then SET_CELL x=3 y=0 colour A
    @(negedge clk);
    pre_addr = 9'd0; pre_data = 16'h1234; pre_we = 1'b1;
    @(negedge clk);
    #1 pre_we = 1'b0;
    mdl[0] = 16'h1234;
    fill_check(OP_SET_CELL, 3, 0, 0, 0, 4'hA);
    chk("rmw_write", 32'(wq[0]), 32'({9'd0, 16'h123A}));

    // CLEAR colour 3
    for (int i = 0; i < 300; i++) mdl[i] = 16'h3333;
    run_cmd(OP_CLEAR, 0, 0, 0, 0, 4'h3);
    chk("clr_done",   32'(got_done), 32'd1);
    chk("clr_cycles", 32'(cyc), 32'd301);
    chk("clr_writes", 32'(nwr), 32'd300);
    chk("clr_reads",  32'(nrmw), 32'd0);
    bad_seq = 0;
    for (int i = 0; i < 300; i++)
      if (i >= wq.size() || wq[i] !== {9'(i), 16'h3333}) bad_seq++;
    chk("clr_seq", 32'(bad_seq), 32'd0);
    chk("clr_ram", 32'(ram_diffs()), 32'd0);

    // Rejected commands
    err_check(OP_SET_CELL, 40, 0, 0, 0);
    err_check(OP_SET_CELL, 0, 30, 0, 0);
    err_check(OP_FILL_RECT, 9, 0, 2, 1);
    err_check(OP_FILL_RECT, 0, 5, 3, 4);
    err_check(OP_RSVD, 1, 1, 1, 1);

    // Random valid rectangles and cells
    for (int k = 0; k < 16; k++) begin
      rx0 = $urandom_range(39, 0);
      rx1 = $urandom_range(39, rx0);
      ry0 = $urandom_range(29, 0);
      ry1 = $urandom_range((ry0 + 3 > 29) ? 29 : ry0 + 3, ry0);
      rop = ($urandom_range(1, 0) == 0) ? OP_SET_CELL : OP_FILL_RECT;
      fill_check(rop, rx0, ry0, rx1, ry1, 4'($urandom_range(15, 0)));
    end

    // Reset during CLEAR at word 100
    @(negedge clk);
    bif.cmd_valid = 1'b1; bif.cmd_op = OP_CLEAR; bif.cmd_color = 4'h5;
    @(posedge clk);
    #1 bif.cmd_valid = 1'b0;
    cyc = 0; hit = 0;
    while (!hit && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      hit = bif.mem_wren && (bif.mem_addr == 9'd100);
    end
    chk("abort_reached", 32'(hit), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_wren",  32'(bif.mem_wren), 32'd0);
    chk("abort_ready", 32'(bif.cmd_ready), 32'd1);
    chk("abort_busy",  32'(bif.busy), 32'd0);
    chk("abort_addr",  32'(bif.mem_addr), 32'd0);
    chk("abort_data",  32'(bif.mem_data), 32'd0);
    for (int i = 0; i <= 100; i++) mdl[i] = 16'h5555;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_nodone", 32'({bif.done, bif.err}), 32'd0);
    chk("abort_ram",    32'(ram_diffs()), 32'd0);
    fill_check(OP_SET_CELL, 7, 29, 0, 0, 4'hC);
    chk("post_rst_write", 32'(wq[0]), 32'({9'd291, 16'h333C}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
